// File: rtl/board_input_conditioner_pkg.sv
// rtl/board_input_conditioner_pkg.sv - shared board constants for the input conditioner
// Purpose : default debounce length and switch-bank width, bit positions of the
//           conditioned inputs inside the internal raw/stable vectors, and the
//           debounce counter width helper.
// Ports   : none (package).
package board_input_conditioner_pkg;

   // 10 ms at 100 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int unsigned N_SW_DEF            = 10;

   // Layout of the internal per-bit vector: stop, debug view, then the switch bank.
   localparam int unsigned BIT_STOP     = 0;
   localparam int unsigned BIT_DEBUG_DM = 1;
   localparam int unsigned BIT_SW_BASE  = 2;
   localparam int unsigned N_EXTRA_BITS = 2;

   // Counter must hold 0..cycles-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/board_input_conditioner_debounce_bit.sv
// rtl/board_input_conditioner_debounce_bit.sv - one-bit synchronizer + debounce counter
// Purpose : brings one raw asynchronous input into clk_i through two flops and
//           only accepts a new level after it has held for DEBOUNCE_CYCLES cycles.
// Ports   : clk_i    - clock, rising edge
//           rst_ni   - asynchronous active-low reset
//           raw_i    - raw asynchronous input
//           stable_o - debounced level (register output)
module debounce_bit
   import board_input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic stable_o
);

   localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any agreement clears the count, so a bounce restarts the full wait.
   // On the last count the new level is taken and the count clears together.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - debounce of stop button, debug switch and switch bank
// Purpose : every raw board input gets its own debounce_bit; the stop level
//           also yields a rising-edge pulse and the switch bank a change pulse.
// Ports   : clk_board      - board clock, rising edge
//           rst_n          - asynchronous active-low reset
//           stop_raw       - raw stop push-button
//           debug_dm_raw   - raw data-memory debug-view switch
//           switch_raw     - raw slide switches [N_SW]
//           stop           - debounced stop level
//           stop_rise      - one-cycle pulse on debounced stop 0->1
//           debug_dm       - debounced debug-view level
//           switch_out     - debounced switch levels [N_SW]
//           switch_changed - one-cycle pulse when any switch_out bit changes
module board_input_conditioner
   import board_input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned N_SW            = N_SW_DEF
) (
   input  logic            clk_board,
   input  logic            rst_n,
   input  logic            stop_raw,
   input  logic            debug_dm_raw,
   input  logic [N_SW-1:0] switch_raw,
   output logic            stop,
   output logic            stop_rise,
   output logic            debug_dm,
   output logic [N_SW-1:0] switch_out,
   output logic            switch_changed
);

   localparam int unsigned NB = N_SW + N_EXTRA_BITS;

   logic [NB-1:0]   raw_vec;
   logic [NB-1:0]   stable_vec;
   logic            stop_prev_q;
   logic [N_SW-1:0] sw_prev_q;

   assign raw_vec[BIT_STOP]              = stop_raw;
   assign raw_vec[BIT_DEBUG_DM]          = debug_dm_raw;
   assign raw_vec[BIT_SW_BASE +: N_SW]   = switch_raw;

   for (genvar i = 0; i < NB; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce_bit (
         .clk_i   (clk_board),
         .rst_ni  (rst_n),
         .raw_i   (raw_vec[i]),
         .stable_o(stable_vec[i])
      );
   end

   assign stop       = stable_vec[BIT_STOP];
   assign debug_dm   = stable_vec[BIT_DEBUG_DM];
   assign switch_out = stable_vec[BIT_SW_BASE +: N_SW];

   // Previous values reset to the same 0 as the stable registers, so neither
   // reset assertion nor release can create a pulse.
   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         stop_prev_q <= 1'b0;
         sw_prev_q   <= '0;
      end else begin
         stop_prev_q <= stop;
         sw_prev_q   <= switch_out;
      end
   end

   assign stop_rise      = stop & ~stop_prev_q;
   assign switch_changed = |(switch_out ^ sw_prev_q);

endmodule

// File: tb/tb_board_input_conditioner.sv
// tb/tb_board_input_conditioner.sv - self-checking bench for board_input_conditioner
module tb_board_input_conditioner;

   localparam int unsigned D    = 4;
   localparam int unsigned N_SW = 10;
   localparam int unsigned NB   = N_SW + 2;

   logic            clk_board = 1'b0;
   logic            rst_n;
   logic            stop_raw;
   logic            debug_dm_raw;
   logic [N_SW-1:0] switch_raw;
   logic            stop;
   logic            stop_rise;
   logic            debug_dm;
   logic [N_SW-1:0] switch_out;
   logic            switch_changed;

   int tests_run    = 0;
   int tests_failed = 0;

   board_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .N_SW           (N_SW)
   ) dut (
      .clk_board     (clk_board),
      .rst_n         (rst_n),
      .stop_raw      (stop_raw),
      .debug_dm_raw  (debug_dm_raw),
      .switch_raw    (switch_raw),
      .stop          (stop),
      .stop_rise     (stop_rise),
      .debug_dm      (debug_dm),
      .switch_out    (switch_out),
      .switch_changed(switch_changed)
   );

   always #5 clk_board = ~clk_board;

   // Reference: a bit's output flips once the raw samples taken 2..D+1 edges
   // ago all disagree with it (two sync stages, then D disagreeing cycles).
   logic [D:0][NB-1:0] hist;
   logic [NB-1:0]      m_out;
   logic               m_rise;
   logic               m_chg;
   logic [NB-1:0]      m_flip;

   function automatic logic [NB-1:0] settled_mask(input logic [D:0][NB-1:0] h,
                                                   input logic [NB-1:0] cur);
      logic [NB-1:0] m;
      m = '1;
      for (int i = 1; i <= int'(D); i++) m &= h[i] ^ cur;
      return m;
   endfunction

   assign m_flip = settled_mask(hist, m_out);

   always @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         hist   <= '0;
         m_out  <= '0;
         m_rise <= 1'b0;
         m_chg  <= 1'b0;
      end else begin
         hist   <= {hist[D-1:0], {switch_raw, debug_dm_raw, stop_raw}};
         m_out  <= m_out ^ m_flip;
         m_rise <= m_flip[0] & ~m_out[0];
         m_chg  <= |m_flip[NB-1:2];
      end
   end

   task automatic step();
      @(posedge clk_board);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if ({stop, stop_rise, debug_dm, switch_out, switch_changed} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs[%0d]: got %0h expected 0", k,
                     {stop, stop_rise, debug_dm, switch_out, switch_changed});
         end
         step();
      end
      rst_n = 1'b1;
      step();
      tests_run++;
      if ({stop_rise, switch_changed} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_release_pulse: got %b expected 00", {stop_rise, switch_changed});
      end
   endtask

   task automatic test_clean_stop();
      stop_raw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         tests_run++;
         if (stop !== (k >= 6) || stop_rise !== (k == 6)) begin
            tests_failed++;
            $display("FAIL clean_stop edge+%0d: got stop=%b rise=%b expected stop=%b rise=%b",
                     k, stop, stop_rise, k >= 6, k == 6);
         end
      end
   endtask

   task automatic test_bounce_stop();
      int pulses;
      stop_raw = 1'b0;
      settle(10);
      tests_run++;
      if (stop !== 1'b0 || stop_rise !== 1'b0) begin
         tests_failed++;
         $display("FAIL stop_fall_no_pulse: got stop=%b rise=%b expected 0 0", stop, stop_rise);
      end
      pulses = 0;
      for (int t = 0; t < 8; t++) begin
         stop_raw = (t % 4) < 2;
         step();
         pulses += int'(stop_rise);
         tests_run++;
         if (stop !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_rejected[%0d]: got stop=%b expected 0", t, stop);
         end
      end
      stop_raw = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         pulses += int'(stop_rise);
         tests_run++;
         if (stop !== (k >= 6)) begin
            tests_failed++;
            $display("FAIL bounce_final edge+%0d: got stop=%b expected %b", k, stop, k >= 6);
         end
      end
      tests_run++;
      if (pulses != 1) begin
         tests_failed++;
         $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
      end
   endtask

   task automatic test_glitch();
      int pulses;
      pulses = 0;
      switch_raw[3] = 1'b1;
      settle(3);
      switch_raw[3] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         pulses += int'(switch_changed);
         tests_run++;
         if (switch_out !== '0) begin
            tests_failed++;
            $display("FAIL glitch_switch_out[%0d]: got %0h expected 0", k, switch_out);
         end
      end
      tests_run++;
      if (pulses != 0) begin
         tests_failed++;
         $display("FAIL glitch_pulses: got %0d expected 0", pulses);
      end
   endtask

   task automatic test_multi_bit();
      int pulses;
      pulses = 0;
      switch_raw = 10'h201;
      for (int k = 1; k <= 10; k++) begin
         step();
         pulses += int'(switch_changed);
         tests_run++;
         if (switch_out !== ((k >= 6) ? 10'h201 : 10'h000) || switch_changed !== (k == 6)) begin
            tests_failed++;
            $display("FAIL multi_bit edge+%0d: got sw=%0h chg=%b expected sw=%0h chg=%b",
                     k, switch_out, switch_changed, (k >= 6) ? 10'h201 : 10'h000, k == 6);
         end
      end
      tests_run++;
      if (pulses != 1) begin
         tests_failed++;
         $display("FAIL multi_bit_pulses: got %0d expected 1", pulses);
      end
   endtask

   task automatic test_back_to_back();
      switch_raw[1] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         if (k == 3) switch_raw[2] = 1'b1;
         step();
         tests_run++;
         if (switch_changed !== (k == 6 || k == 8)) begin
            tests_failed++;
            $display("FAIL back_to_back edge+%0d: got chg=%b expected %b",
                     k, switch_changed, k == 6 || k == 8);
         end
      end
      tests_run++;
      if (switch_out !== 10'h207) begin
         tests_failed++;
         $display("FAIL back_to_back_final: got %0h expected 207", switch_out);
      end
   endtask

   task automatic test_reset_mid();
      stop_raw = 1'b0;
      settle(10);
      stop_raw = 1'b1;
      settle(4);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({stop, stop_rise, debug_dm, switch_out, switch_changed} !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs: got %0h expected 0",
                  {stop, stop_rise, debug_dm, switch_out, switch_changed});
      end
      @(posedge clk_board);
      #1;
      rst_n = 1'b1;
      tests_run++;
      if ({stop_rise, switch_changed} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_mid_release_pulse: got %b expected 00", {stop_rise, switch_changed});
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         tests_run++;
         if (stop !== (k >= 6) || stop_rise !== (k == 6) || switch_changed !== (k == 6)) begin
            tests_failed++;
            $display("FAIL reset_mid edge+%0d: got stop=%b rise=%b chg=%b expected %b %b %b",
                     k, stop, stop_rise, switch_changed, k >= 6, k == 6, k == 6);
         end
      end
   endtask

   task automatic test_random(input int cycles);
      logic [NB-1:0] r;
      for (int c = 0; c < cycles; c++) begin
         r = {switch_raw, debug_dm_raw, stop_raw};
         for (int b = 0; b < int'(NB); b++) begin
            if ($urandom_range(0, 6) == 0) r[b] = ~r[b];
         end
         {switch_raw, debug_dm_raw, stop_raw} = r;
         step();
         tests_run++;
         if ({stop_rise, switch_changed, switch_out, debug_dm, stop} !== {m_rise, m_chg, m_out}) begin
            tests_failed++;
            $display("FAIL random[%0d]: got %0h expected %0h", c,
                     {stop_rise, switch_changed, switch_out, debug_dm, stop}, {m_rise, m_chg, m_out});
         end
      end
   endtask

   initial begin
      rst_n        = 1'b1;
      stop_raw     = 1'b0;
      debug_dm_raw = 1'b0;
      switch_raw   = '0;
      #2;
      test_reset();
      settle(3);
      test_clean_stop();
      test_bounce_stop();
      test_glitch();
      test_multi_bit();
      test_back_to_back();
      test_reset_mid();
      test_random(3000);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/board_input_conditioner.md
BOARD_INPUT_CONDITIONER -- requirements
Module: board_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of clk_board cycles an input must hold a new value before it is accepted (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter N_SW, default 10, meaning the switch bank width.
REQ-003 SHALL have port clk_board  input  1  board clock; the single clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stop_raw  input  1  raw stop push-button, asynchronous to clk_board.
REQ-006 SHALL have port debug_dm_raw  input  1  raw data-memory debug-view slide switch.
REQ-007 SHALL have port switch_raw  input  N_SW  raw slide switches.
REQ-008 SHALL have port stop  output  1  debounced stop level, drives Clk and CPU.
REQ-009 SHALL have port stop_rise  output  1  one-cycle pulse on a debounced stop 0->1 transition.
REQ-010 SHALL have port debug_dm  output  1  debounced debug-view level.
REQ-011 SHALL have port switch_out  output  N_SW  debounced switch levels, drives CPU switch_in.
REQ-012 SHALL have port switch_changed  output  1  one-cycle pulse when any debounced switch_out bit changes.

Function
REQ-013 SHALL pass every raw input bit through its own two-flop synchronizer; the second flop output is the "synced" value.
REQ-014 SHALL keep, per bit, a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-015 SHALL clear the counter in any cycle in which the synced value equals stable.
REQ-016 SHALL increment the counter in each cycle in which synced differs from stable and the counter is below DEBOUNCE_CYCLES-1.
REQ-017 SHALL, when synced differs from stable and the counter equals DEBOUNCE_CYCLES-1, load stable from synced and clear the counter in the same edge.
REQ-018 SHALL give a total latency of exactly DEBOUNCE_CYCLES+2 clk_board edges from a clean raw transition to the stable output change.
REQ-019 SHALL reject any raw pulse or bounce train whose synced value returns to stable before the counter reaches DEBOUNCE_CYCLES-1; the output is unchanged and the counter restarts from 0 at the next disagreement.
REQ-020 SHALL drive stop, debug_dm and switch_out directly from the stable registers, with no combinational path from raw inputs.
REQ-021 SHALL assert stop_rise for exactly the first cycle in which stop is 1 (stop & ~stop_prev); a stop 1->0 change produces no pulse.
REQ-022 SHALL assert switch_changed for exactly the first cycle after any switch_out bit changes.
REQ-023 SHALL give exactly one pulse when several bits change on the same edge, and separate pulses when the changes land on different edges.
REQ-024 SHALL treat every bit independently; activity on one bit never affects another bit's counter.

Reset
REQ-025 SHALL, while rst_n is low, force all synchronizer flops, stable registers, counters, previous-value registers, stop, stop_rise, debug_dm, switch_out and switch_changed to 0.
REQ-026 SHALL abandon any in-progress debounce on reset mid-count; after release, a raw value of 1 reappears on the output DEBOUNCE_CYCLES+2 edges later.
REQ-027 SHALL produce no stop_rise or switch_changed pulse as a direct consequence of reset assertion or release.

Structure
REQ-028 SHALL take DEBOUNCE_CYCLES default and N_SW default from the shared definitions package (def.vh), next to the existing board constants.
REQ-029 SHALL use one sub-module, debounce_bit (synchronizer + counter + stable register), instantiated N_SW+2 times; edge detection stays in the top.
REQ-030 SHALL be instantiated in main between the board pins and the CPU/Clk stop, Debug_DM and switch_in inputs.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 SHALL check a clean stop_raw 0->1 at edge 10: stop=1 from edge 16, stop_rise=1 only during cycle 16-17.
REQ-032 SHALL check stop_raw toggling 1,0,1,0 every 2 cycles, then steady 1: stop rises exactly 6 edges after the final 0->1, with a single stop_rise pulse.
REQ-033 SHALL check a 3-cycle glitch on switch_raw[3]: switch_out stays 0x000 and switch_changed never asserts.
REQ-034 SHALL check switch_raw 0x000->0x201 on one edge: switch_out=0x201 after 6 edges and exactly one switch_changed pulse.
REQ-035 SHALL check rst_n low for 1 cycle with the counter at 2 and stop_raw=1: all outputs 0 immediately; stop=1 again 6 edges after release; no pulse at reset release.
